i2s_adc_rx: RTL

- I2S serial-audio receiver: captures the codec ADC stream (BCK/LRCK/DAT driven by the codec-side master) into parallel 16-bit left/right words.
- Counterpart of the a_codec DAC transmitter. Runs entirely in the iCLK (27 MHz) domain by oversampling the serial pins; no logic is clocked by BCK.
- Feeds line-in samples, and optionally a tape bit, to the core.

---
 rtl/a_codec_pkg.sv | 17 +
 rtl/i2s_pin_sync.sv | 31 +++
 rtl/i2s_adc_rx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/a_codec_pkg.sv
// Shared types and constants for the codec serial-audio blocks.
package a_codec_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    localparam int TAPE_MID = 128;

endpackage

// File: rtl/i2s_pin_sync.sv
// Two-flop synchroniser for one serial pin plus a third flop for edge detection.
module i2s_pin_sync
    import a_codec_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic toggle
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign level  = sync_p1;
    assign toggle = sync_p1 ^ sync_p2;

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver, oversampled in the iCLK domain; yields parallel left/right words.
// Optional tape-bit comparator on the left channel is enabled by TAPE_COMPARATOR_EN.
module i2s_adc_rx
    import a_codec_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int I2S_DELAY  = 1
`ifdef TAPE_COMPARATOR_EN
    ,
    parameter int HYST       = 3
`endif
) (
    input  logic                         iCLK,
    input  logic                         oAUD_ADCLRCK,
    input  logic                         iAUD_BCK,
    input  logic                         iAUD_LRCK,
    input  logic                         iAUD_ADCDAT,
    output logic signed [DATA_WIDTH-1:0] oSL,
    output logic signed [DATA_WIDTH-1:0] oSR,
    output logic                         oValid,
    output logic                         oErr,
    output logic                         o_tape
);

    localparam int CNT_W    = $clog2(DATA_WIDTH + 2);
    localparam int IDX_W    = $clog2(DATA_WIDTH);
    localparam int SLOT_END = DATA_WIDTH + I2S_DELAY;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_END);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic bck_level;
    logic bck_toggle;
    logic lr_level;
    logic lr_toggle;
    logic dat_level;
    logic dat_toggle_unused;

    i2s_pin_sync u_sync_bck (
        .clk    (iCLK),
        .rst_n  (oAUD_ADCLRCK),
        .pin    (iAUD_BCK),
        .level  (bck_level),
        .toggle (bck_toggle)
    );

    i2s_pin_sync u_sync_lr (
        .clk    (iCLK),
        .rst_n  (oAUD_ADCLRCK),
        .pin    (iAUD_LRCK),
        .level  (lr_level),
        .toggle (lr_toggle)
    );

    i2s_pin_sync u_sync_dat (
        .clk    (iCLK),
        .rst_n  (oAUD_ADCLRCK),
        .pin    (iAUD_ADCDAT),
        .level  (dat_level),
        .toggle (dat_toggle_unused)
    );

    logic bck_rise;
    logic lr_rise;
    logic lr_fall;

    assign bck_rise = bck_toggle & bck_level;
    assign lr_rise  = lr_toggle & (lr_level == LR_RIGHT);
    assign lr_fall  = lr_toggle & (lr_level == LR_LEFT);

    // Bit at slot position cnt lands MSB-first; the delay slot and any overflow bits fall outside the window.
    function automatic logic [DATA_WIDTH-1:0] place_bit(
        input logic [DATA_WIDTH-1:0] word,
        input logic [CNT_W-1:0]      cnt,
        input logic                  b
    );
        logic [DATA_WIDTH-1:0] w;
        int pos;
        w   = word;
        pos = SLOT_END - 1 - int'(cnt);
        if (int'(cnt) >= I2S_DELAY && int'(cnt) < SLOT_END)
            w[IDX_W'(pos)] = b;
        return w;
    endfunction

    rx_state_t state;
    rx_state_t state_nxt;
    logic      latch_left;
    logic      latch_frame;

    always_ff @(posedge iCLK or negedge oAUD_ADCLRCK) begin
        if (!oAUD_ADCLRCK)
            state <= SYNC;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        latch_left  = 1'b0;
        latch_frame = 1'b0;
        unique case (state)
            SYNC: begin
                if (lr_fall)
                    state_nxt = LEFT;
            end
            LEFT: begin
                if (lr_rise) begin
                    state_nxt  = RIGHT;
                    latch_left = 1'b1;
                end
            end
            RIGHT: begin
                if (lr_fall) begin
                    state_nxt   = LEFT;
                    latch_frame = 1'b1;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    // Slot capture: an LR edge opens a new slot even if BCK rises in the same cycle.
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  slot_short;

    always_ff @(posedge iCLK or negedge oAUD_ADCLRCK) begin
        if (!oAUD_ADCLRCK) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (lr_toggle) begin
            bit_cnt <= bck_rise ? CNT_ONE : '0;
            shreg   <= bck_rise ? place_bit('0, '0, dat_level) : '0;
        end else if (bck_rise) begin
            shreg <= place_bit(shreg, bit_cnt, dat_level);
            if (bit_cnt != CNT_MAX)
                bit_cnt <= bit_cnt + CNT_ONE;
        end
    end

    assign slot_short = int'(bit_cnt) < SLOT_END;

    logic signed [DATA_WIDTH-1:0] word_left;
    logic                         err_left;

    always_ff @(posedge iCLK or negedge oAUD_ADCLRCK) begin
        if (!oAUD_ADCLRCK) begin
            word_left <= '0;
            err_left  <= 1'b0;
            oSL       <= '0;
            oSR       <= '0;
            oValid    <= 1'b0;
            oErr      <= 1'b0;
        end else begin
            oValid <= latch_frame;
            if (latch_left) begin
                word_left <= shreg;
                err_left  <= slot_short;
            end
            if (latch_frame) begin
                oSL  <= word_left;
                oSR  <= shreg;
                oErr <= err_left | slot_short;
            end
        end
    end

`ifdef TAPE_COMPARATOR_EN
    localparam int TAPE_LO = TAPE_MID - HYST;
    localparam int TAPE_HI = TAPE_MID + HYST;

    // Top byte of the sample in offset-binary, compared with a hysteresis band around mid-scale.
    function automatic logic tape_next(
        input logic                  cur,
        input logic [DATA_WIDTH-1:0] w
    );
        logic [7:0] t;
        t = {~w[DATA_WIDTH-1], w[DATA_WIDTH-2 -: 7]};
        if (int'(t) < TAPE_LO)
            return 1'b1;
        else if (int'(t) > TAPE_HI)
            return 1'b0;
        return cur;
    endfunction

    always_ff @(posedge iCLK or negedge oAUD_ADCLRCK) begin
        if (!oAUD_ADCLRCK)
            o_tape <= 1'b0;
        else if (latch_frame)
            o_tape <= tape_next(o_tape, word_left);
    end
`else
    assign o_tape = 1'b0;
`endif

endmodule
